// File: rtl/pulse_window_ctrl.sv
// Run controller: counts y_i pulses between consecutive x_i strobes and
// reports match/miss/timeout per window, with run sequencing under register control.
//
// state | meaning
// IDLE  | waiting for start_i, config latched on accept
// ARM   | run active, waiting for the x_i that opens a window
// COUNT | window open, counting y_i and running the timeout timer
module pulse_window_ctrl #(
  parameter int CNT_W  = 4,
  parameter int TMO_W  = 8,
  parameter int NWIN_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [CNT_W-1:0]  cfg_min_i,
  input  logic [CNT_W-1:0]  cfg_max_i,
  input  logic [TMO_W-1:0]  cfg_tmo_i,
  input  logic [NWIN_W-1:0] cfg_nwin_i,
  input  logic              x_i,
  input  logic              y_i,
  output logic              busy_o,
  output logic              match_o,
  output logic              miss_o,
  output logic              timeout_o,
  output logic              done_o,
  output logic [NWIN_W-1:0] match_cnt_o
);

  typedef enum logic [1:0] {IDLE, ARM, COUNT} state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [NWIN_W-1:0] NWIN_MAX = {NWIN_W{1'b1}};

  state_t            state;
  logic [CNT_W-1:0]  min_q;
  logic [CNT_W-1:0]  max_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [NWIN_W-1:0] nwin_q;
  logic [CNT_W-1:0]  ycnt;
  logic [TMO_W-1:0]  tmr;
  logic [NWIN_W-1:0] win_cnt;

  logic              in_range;
  logic [NWIN_W-1:0] win_nxt;
  logic              last_win;
  logic              tmo_hit;

  // tmr is a down-counter loaded with tmo-1 when a window opens; terminal count 0
  // is equivalent to an up-counter reaching tmo-1.
  assign in_range = (ycnt >= min_q) && (ycnt <= max_q);
  assign win_nxt  = win_cnt + NWIN_W'(1);
  assign last_win = (nwin_q != '0) && (win_nxt == nwin_q);
  assign tmo_hit  = (tmo_q != '0) && (tmr == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      min_q       <= '0;
      max_q       <= '0;
      tmo_q       <= '0;
      nwin_q      <= '0;
      ycnt        <= '0;
      tmr         <= '0;
      win_cnt     <= '0;
      busy_o      <= 1'b0;
      match_o     <= 1'b0;
      miss_o      <= 1'b0;
      timeout_o   <= 1'b0;
      done_o      <= 1'b0;
      match_cnt_o <= '0;
    end else begin
      match_o   <= 1'b0;
      miss_o    <= 1'b0;
      timeout_o <= 1'b0;
      done_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            min_q       <= cfg_min_i;
            max_q       <= cfg_max_i;
            tmo_q       <= cfg_tmo_i;
            nwin_q      <= cfg_nwin_i;
            match_cnt_o <= '0;
            win_cnt     <= '0;
            busy_o      <= 1'b1;
            state       <= ARM;
          end
        end
        ARM: begin
          if (stop_i) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else if (x_i) begin
            ycnt  <= '0;
            tmr   <= tmo_q - TMO_W'(1);
            state <= COUNT;
          end
        end
        COUNT: begin
          if (stop_i) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else if (x_i) begin
            match_o <= in_range;
            miss_o  <= !in_range;
            if (in_range && (match_cnt_o != NWIN_MAX))
              match_cnt_o <= match_cnt_o + NWIN_W'(1);
            win_cnt <= win_nxt;
            if (last_win) begin
              done_o <= 1'b1;
              busy_o <= 1'b0;
              state  <= IDLE;
            end else begin
              // a y coincident with the closing x belongs to the next window
              ycnt <= y_i ? CNT_W'(1) : '0;
              tmr  <= tmo_q - TMO_W'(1);
            end
          end else if (tmo_hit) begin
            timeout_o <= 1'b1;
            state     <= ARM;
          end else begin
            tmr <= tmr - TMO_W'(1);
            if (y_i && (ycnt != CNT_MAX))
              ycnt <= ycnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_window_ctrl.sv
// Bench for pulse_window_ctrl: hand-derived per-cycle event expectations are queued
// as stimulus is driven and compared against the DUT one edge later.
module tb_pulse_window_ctrl;

  localparam logic [3:0] E_NONE  = 4'b0000;
  localparam logic [3:0] E_MATCH = 4'b1000;
  localparam logic [3:0] E_MISS  = 4'b0100;
  localparam logic [3:0] E_TMO   = 4'b0010;
  localparam logic [3:0] E_DONE  = 4'b0001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_i = 1'b0;
  logic       stop_i = 1'b0;
  logic [3:0] cfg_min_i = '0;
  logic [3:0] cfg_max_i = '0;
  logic [7:0] cfg_tmo_i = '0;
  logic [3:0] cfg_nwin_i = '0;
  logic       x_i = 1'b0;
  logic       y_i = 1'b0;
  logic       busy_o, match_o, miss_o, timeout_o, done_o;
  logic [3:0] match_cnt_o;

  int total = 0;
  int bad = 0;
  logic [3:0] sb[$];

  pulse_window_ctrl #(.CNT_W(4), .TMO_W(8), .NWIN_W(4)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .stop_i(stop_i),
    .cfg_min_i(cfg_min_i), .cfg_max_i(cfg_max_i), .cfg_tmo_i(cfg_tmo_i),
    .cfg_nwin_i(cfg_nwin_i), .x_i(x_i), .y_i(y_i), .busy_o(busy_o),
    .match_o(match_o), .miss_o(miss_o), .timeout_o(timeout_o),
    .done_o(done_o), .match_cnt_o(match_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // drive one cycle of inputs and queue the event vector expected after the edge
  task automatic drv(input logic x, input logic y, input logic st, input logic sp,
                     input logic rs, input logic [3:0] e);
    @(negedge clk);
    x_i = x; y_i = y; start_i = st; stop_i = sp; reset = rs;
    sb.push_back(e);
  endtask

  task automatic post(input string tag, input logic busy_exp, input int cnt_exp);
    @(posedge clk);
    #2;
    chk({tag, "_busy"}, busy_o, busy_exp);
    chk({tag, "_cnt"}, match_cnt_o, cnt_exp);
  endtask

  task automatic cfg(input int mn, input int mx, input int tmo, input int nw);
    cfg_min_i = 4'(mn); cfg_max_i = 4'(mx); cfg_tmo_i = 8'(tmo); cfg_nwin_i = 4'(nw);
  endtask

  always @(posedge clk) begin
    logic [3:0] e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("evt", {match_o, miss_o, timeout_o, done_o}, e);
    end
  end

  initial begin
    drv(0, 0, 0, 0, 1, E_NONE);
    drv(0, 0, 0, 0, 1, E_NONE);
    post("reset", 1'b0, 0);

    // windows of 2, 3, 1 y's against range [2,2], three-window run
    cfg(2, 2, 0, 3);
    drv(0, 0, 1, 0, 0, E_NONE);
    post("t1_start", 1'b1, 0);
    cfg(0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, E_NONE);
    repeat (2) drv(0, 1, 0, 0, 0, E_NONE);
    drv(1, 0, 0, 0, 0, E_MATCH);
    repeat (3) drv(0, 1, 0, 0, 0, E_NONE);
    drv(1, 0, 0, 0, 0, E_MISS);
    drv(0, 1, 0, 0, 0, E_NONE);
    drv(1, 0, 0, 0, 0, E_MISS | E_DONE);
    post("t1_end", 1'b0, 1);

    // y ignored when opening from ARM; y coincident with closing x carries over
    cfg(1, 1, 0, 2);
    drv(0, 0, 1, 0, 0, E_NONE);
    drv(1, 1, 0, 0, 0, E_NONE);
    drv(1, 1, 0, 0, 0, E_MISS);
    drv(1, 0, 0, 0, 0, E_MATCH | E_DONE);
    post("t2_end", 1'b0, 1);

    // timeout 5 cycles after open, back to ARM, then a matching window
    cfg(0, 1, 5, 1);
    drv(0, 0, 1, 0, 0, E_NONE);
    drv(1, 0, 0, 0, 0, E_NONE);
    repeat (4) drv(0, 0, 0, 0, 0, E_NONE);
    drv(0, 0, 0, 0, 0, E_TMO);
    post("t3_tmo", 1'b1, 0);
    drv(0, 1, 0, 0, 0, E_NONE);
    drv(1, 0, 0, 0, 0, E_NONE);
    drv(0, 1, 0, 0, 0, E_NONE);
    drv(1, 0, 0, 0, 0, E_MATCH | E_DONE);
    post("t3_end", 1'b0, 1);

    // close on the same cycle the timer expires: close wins
    cfg(0, 0, 2, 1);
    drv(0, 0, 1, 0, 0, E_NONE);
    drv(1, 0, 0, 0, 0, E_NONE);
    drv(0, 0, 0, 0, 0, E_NONE);
    drv(1, 0, 0, 0, 0, E_MATCH | E_DONE);

    // y count saturates at 15
    cfg(15, 15, 0, 1);
    drv(0, 0, 1, 0, 0, E_NONE);
    drv(1, 0, 0, 0, 0, E_NONE);
    repeat (20) drv(0, 1, 0, 0, 0, E_NONE);
    drv(1, 0, 0, 0, 0, E_MATCH | E_DONE);
    post("t4_end", 1'b0, 1);

    // min > max always misses
    cfg(3, 1, 0, 1);
    drv(0, 0, 1, 0, 0, E_NONE);
    drv(1, 0, 0, 0, 0, E_NONE);
    repeat (2) drv(0, 1, 0, 0, 0, E_NONE);
    drv(1, 0, 0, 0, 0, E_MISS | E_DONE);

    // continuous run, stop with x and start in the same cycle
    cfg(0, 15, 0, 0);
    drv(0, 0, 1, 0, 0, E_NONE);
    drv(1, 0, 0, 0, 0, E_NONE);
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 0, 0, 0, E_NONE);
      drv(1, 0, 0, 0, 0, E_MATCH);
    end
    drv(1, 0, 1, 1, 0, E_DONE);
    post("t5_stop", 1'b0, 4);
    drv(0, 0, 0, 0, 0, E_NONE);
    post("t5_hold", 1'b0, 4);

    // match counter saturates at 15
    drv(0, 0, 1, 0, 0, E_NONE);
    drv(1, 0, 0, 0, 0, E_NONE);
    repeat (17) drv(1, 0, 0, 0, 0, E_MATCH);
    drv(0, 0, 0, 1, 0, E_DONE);
    post("t5_sat", 1'b0, 15);

    // reset mid-COUNT aborts silently
    cfg(0, 15, 0, 0);
    drv(0, 0, 1, 0, 0, E_NONE);
    drv(1, 0, 0, 0, 0, E_NONE);
    drv(0, 1, 0, 0, 0, E_NONE);
    drv(1, 0, 0, 0, 0, E_MATCH);
    repeat (2) drv(0, 1, 0, 0, 0, E_NONE);
    drv(0, 0, 0, 0, 1, E_NONE);
    post("t6_reset", 1'b0, 0);
    cfg(2, 2, 0, 1);
    drv(0, 0, 1, 0, 0, E_NONE);
    drv(1, 0, 0, 0, 0, E_NONE);
    repeat (2) drv(0, 1, 0, 0, 0, E_NONE);
    drv(1, 0, 0, 0, 0, E_MATCH | E_DONE);
    post("t6_end", 1'b0, 1);

    drv(0, 0, 0, 0, 0, E_NONE);
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
